serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract controller that computes one WIDTH-bit result by driving a single `adder_1_bit` instance for WIDTH consecutive cycles. It holds the carry between cycles, shifts the operands LSB-first through the adder and assembles the result. A start/ready/done handshake lets a host sequencer time-share the 1-bit datapath instead of instantiating a full-width adder.

---
 rtl/serial_adder_ctrl.sv | 108 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract controller time-sharing one adder_1_bit over WIDTH cycles.
module adder_1_bit (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d, co_q, co_d, ov_q, ov_d;
    logic             add_s, add_co;

    adder_1_bit u_add (sa_q[0], sb_q[0], cy_q, add_s, add_co);

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        co_d    = co_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                sa_d    = op_a;
                sb_d    = sub ? ~op_b : op_b;
                cy_d    = sub;
                cnt_d   = '0;
                res_d   = '0;
                co_d    = 1'b0;
                ov_d    = 1'b0;
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cy_d  = add_co;
                res_d = {add_s, res_q[WIDTH-1:1]};
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    co_d    = add_co;
                    ov_d    = cy_q ^ add_co;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign ready     = state_q == IDLE;
    assign busy      = state_q == RUN;
    assign done      = state_q == DONE;
    assign result    = res_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of the serial add/subtract controller at WIDTH=8.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       ready, busy, done, carry_out, overflow;
    logic [7:0] result;
    int         checks = 0;
    int         failures = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
        .ready(ready), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_ready"}, 32'(ready), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_result"}, 32'(result), 0);
        check({tag, "_co"}, 32'(carry_out), 0);
        check({tag, "_ov"}, 32'(overflow), 0);
    endtask

    // ign=1 pokes start with AA/55 during RUN cycle 3 and leaves it held from the DONE cycle on
    task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] er, input logic eco, input logic eov, input logic ign);
        check({tag, "_ready_pre"}, 32'(ready), 1);
        op_a = a; op_b = b; sub = s; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check({tag, "_busy"}, 32'(busy), 1);
            check({tag, "_nodone"}, 32'(done), 0);
            check({tag, "_notready"}, 32'(ready), 0);
            if (ign && i == 2) begin
                op_a = 8'hAA; op_b = 8'h55; sub = 1'b0; start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy_off"}, 32'(busy), 0);
        check({tag, "_ready_in_done"}, 32'(ready), 0);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_co"}, 32'(carry_out), 32'(eco));
        check({tag, "_ov"}, 32'(overflow), 32'(eov));
        if (ign) begin
            op_a = 8'hAA; op_b = 8'h55; sub = 1'b0; start = 1'b1;
        end
        tick();
        check({tag, "_ready_post"}, 32'(ready), 1);
        check({tag, "_done_post"}, 32'(done), 0);
        check({tag, "_result_hold"}, 32'(result), 32'(er));
        check({tag, "_co_hold"}, 32'(carry_out), 32'(eco));
        check({tag, "_ov_hold"}, 32'(overflow), 32'(eov));
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check_idle_reset("reset");
        tick();
        check_idle_reset("idle_hold");

        op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
        op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        op("sub_03_05", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);

        op("ign_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        op("held_aa_55", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);

        op_a = 8'h11; op_b = 8'h22; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_reset("mid_reset");
        for (int i = 0; i < 10; i++) begin
            check("mid_no_done", 32'(done), 0);
            tick();
        end
        op("add_20_22", 8'h20, 8'h22, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0);

        reset = 1'b1; start = 1'b1; op_a = 8'h01; op_b = 8'h01;
        tick();
        reset = 1'b0; start = 1'b0;
        check_idle_reset("reset_start");
        tick();
        check("reset_start_dropped", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
